// File: rtl/qos_sched_pkg.sv
// ---------------------------------------------------------------------------
// qos_sched_pkg
// Shared constants, types and helpers for the QoS virtual-channel scheduler.
//   - Geometry: QUEUE_QUANTITY VCs, TABLE_SIZE arbitration entries,
//     WW-bit weights, VCW-bit VC ids, MDW-bit policy select.
//   - Policy codes RR_NORMAL / RR_PESADO / RR_ARBITRADO (code 3 acts as RR).
//   - FSM states S_IDLE / S_ACTIVE.
//   - eff_weight(): maps a configured weight to the number of pops granted.
// ---------------------------------------------------------------------------
package qos_sched_pkg;

    localparam int QUEUE_QUANTITY    = 4;
    localparam int MAX_WEIGHT        = 64;
    localparam int TABLE_SIZE        = 8;
    localparam int TIPOS_ROUND_ROBIN = 3;

    localparam int WW  = $clog2(MAX_WEIGHT);
    localparam int VCW = $clog2(QUEUE_QUANTITY);
    localparam int MDW = $clog2(TIPOS_ROUND_ROBIN);
    localparam int TIW = $clog2(TABLE_SIZE);
    localparam int GCW = 8;

    localparam logic [MDW-1:0] RR_NORMAL    = 2'd0;
    localparam logic [MDW-1:0] RR_PESADO    = 2'd1;
    localparam logic [MDW-1:0] RR_ARBITRADO = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } sched_state_e;

    // A configured weight of zero still grants one pop per visit.
    function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        if (w == {WW{1'b0}}) begin
            r = {{(WW-1){1'b0}}, 1'b1};
        end else begin
            r = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/qos_rr_next.sv
// ---------------------------------------------------------------------------
// qos_rr_next
// Combinational search for the next non-empty VC in cyclic order after
// i_start. i_start itself is the last candidate, so a lone non-empty VC is
// selected again. o_none is set when every VC is empty (o_next = i_start).
//   i_empty [QUEUE_QUANTITY]  empty flags of the VC FIFOs
//   i_start [VCW]             current VC
//   o_next  [VCW]             next VC to serve
//   o_none  1                 no VC holds data
// ---------------------------------------------------------------------------
module qos_rr_next
    import qos_sched_pkg::*;
(
    input  logic [QUEUE_QUANTITY-1:0] i_empty,
    input  logic [VCW-1:0]            i_start,
    output logic [VCW-1:0]            o_next,
    output logic                      o_none
);

    logic [VCW-1:0] w_idx;

    // Scan farthest to nearest so the closest non-empty VC is the one kept
    always_comb begin
        o_next = i_start;
        o_none = 1'b1;
        w_idx  = i_start;
        for (int k = QUEUE_QUANTITY; k >= 1; k--) begin
            w_idx  = i_start + VCW'(k);
            o_next = i_empty[w_idx] ? o_next : w_idx;
            o_none = o_none & i_empty[w_idx];
        end
    end

endmodule

// File: rtl/qos_vc_scheduler.sv
// ---------------------------------------------------------------------------
// qos_vc_scheduler
// Chooses which VC FIFO is popped into the output FIFO each cycle using
// round-robin, weighted round-robin or table arbitration. Configuration is
// captured on `iniciar`, so the config buses may change while running.
// Optional macro QOS_SCHED_STATS_EN adds per-VC saturating grant counters.
// Ports:
//   clk, rst (sync, active-high), enb (global enable), iniciar (start pulse)
//   mem_seleccion_roundRobin  policy select
//   mem_pesos                 per-VC weights, VC0 in LSBs
//   mem_pesosArbitraje        per-entry table weights, entry 0 in LSBs
//   mem_selecciones           per-entry table VC ids, entry 0 in LSBs
//   vc_empty                  VC FIFO empty flags
//   out_full, out_almost_full output FIFO status
//   grant_count               (QOS_SCHED_STATS_EN only) 8-bit count per VC
//   vc_pop                    one-hot VC read enable
//   out_push                  output write enable, one cycle after vc_pop
//   out_sel                   VC feeding the data mux during out_push
//   idle                      nothing in flight
// ---------------------------------------------------------------------------
module qos_vc_scheduler
    import qos_sched_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enb,
    input  logic                          iniciar,
    input  logic [MDW-1:0]                mem_seleccion_roundRobin,
    input  logic [QUEUE_QUANTITY*WW-1:0]  mem_pesos,
    input  logic [TABLE_SIZE*WW-1:0]      mem_pesosArbitraje,
    input  logic [TABLE_SIZE*VCW-1:0]     mem_selecciones,
    input  logic [QUEUE_QUANTITY-1:0]     vc_empty,
    input  logic                          out_full,
    input  logic                          out_almost_full,
`ifdef QOS_SCHED_STATS_EN
    output logic [QUEUE_QUANTITY*GCW-1:0] grant_count,
`endif
    output logic [QUEUE_QUANTITY-1:0]     vc_pop,
    output logic                          out_push,
    output logic [VCW-1:0]                out_sel,
    output logic                          idle
);

    sched_state_e                r_state;
    logic [MDW-1:0]              r_mode;
    logic [QUEUE_QUANTITY*WW-1:0] r_pesos;
    logic [TABLE_SIZE*WW-1:0]    r_pesos_arb;
    logic [TABLE_SIZE*VCW-1:0]   r_sel;
    logic [VCW-1:0]              r_cur_vc;
    logic [TIW-1:0]              r_tbl_idx;
    logic [WW-1:0]               r_credit;
    logic                        r_push;
    logic [VCW-1:0]              r_out_sel;

    logic                        w_active;
    logic                        w_is_table;
    logic                        w_is_weighted;
    logic [VCW-1:0]              w_target;
    logic                        w_target_empty;
    logic                        w_pop;
    logic                        w_advance;
    logic [VCW-1:0]              w_next_vc;
    logic                        w_none;
    logic [TIW-1:0]              w_next_tbl;
    logic [WW-1:0]               w_next_vc_credit;
    logic [WW-1:0]               w_next_tbl_credit;
    logic [WW-1:0]               w_init_credit;

    assign w_active       = (r_state == S_ACTIVE);
    assign w_is_table     = (r_mode == RR_ARBITRADO);
    assign w_is_weighted  = (r_mode == RR_PESADO);
    assign w_target       = w_is_table ? r_sel[r_tbl_idx*VCW +: VCW] : r_cur_vc;
    assign w_target_empty = vc_empty[w_target];

    // A pending push into a one-slot-free output FIFO would fill it, so hold off.
    assign w_pop = w_active & enb & ~w_target_empty & ~out_full
                 & ~(r_push & out_almost_full);

    // Leave the target once its credit is spent or it has nothing to give;
    // a blocked but non-empty target keeps both its credit and its turn.
    assign w_advance = w_active & enb
                     & (w_target_empty | (w_pop & (r_credit == WW'(1))));

    assign w_next_tbl        = r_tbl_idx + TIW'(1);
    assign w_next_vc_credit  = w_is_weighted ? eff_weight(r_pesos[w_next_vc*WW +: WW]) : WW'(1);
    assign w_next_tbl_credit = eff_weight(r_pesos_arb[w_next_tbl*WW +: WW]);

    qos_rr_next u_rr_next (
        .i_empty (vc_empty),
        .i_start (r_cur_vc),
        .o_next  (w_next_vc),
        .o_none  (w_none)
    );

    // Credit of the first target, taken straight from the buses being captured
    always_comb begin
        case (mem_seleccion_roundRobin)
            RR_NORMAL:    w_init_credit = WW'(1);
            RR_PESADO:    w_init_credit = eff_weight(mem_pesos[WW-1:0]);
            RR_ARBITRADO: w_init_credit = eff_weight(mem_pesosArbitraje[WW-1:0]);
            default:      w_init_credit = WW'(1);
        endcase
    end

    // One-hot read enable for the current target
    always_comb begin
        vc_pop = {QUEUE_QUANTITY{1'b0}};
        if (w_pop) begin
            vc_pop[w_target] = 1'b1;
        end else begin
            vc_pop = {QUEUE_QUANTITY{1'b0}};
        end
    end

    assign out_push = r_push & enb;
    assign out_sel  = r_out_sel;
    assign idle     = ~w_active | (&vc_empty & ~out_push);

    // Scheduler FSM: snapshot, pointer/credit bookkeeping and push pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= RR_NORMAL;
            r_pesos     <= {(QUEUE_QUANTITY*WW){1'b0}};
            r_pesos_arb <= {(TABLE_SIZE*WW){1'b0}};
            r_sel       <= {(TABLE_SIZE*VCW){1'b0}};
            r_cur_vc    <= {VCW{1'b0}};
            r_tbl_idx   <= {TIW{1'b0}};
            r_credit    <= {WW{1'b0}};
            r_push      <= 1'b0;
            r_out_sel   <= {VCW{1'b0}};
        end else if (enb) begin
            r_push <= w_pop;
            if (w_pop) begin
                r_out_sel <= w_target;
            end
            if (iniciar) begin
                r_state     <= S_ACTIVE;
                r_mode      <= mem_seleccion_roundRobin;
                r_pesos     <= mem_pesos;
                r_pesos_arb <= mem_pesosArbitraje;
                r_sel       <= mem_selecciones;
                r_cur_vc    <= {VCW{1'b0}};
                r_tbl_idx   <= {TIW{1'b0}};
                r_credit    <= w_init_credit;
            end else if (w_active) begin
                if (w_is_table) begin
                    if (w_advance) begin
                        r_tbl_idx <= w_next_tbl;
                        r_credit  <= w_next_tbl_credit;
                    end else if (w_pop) begin
                        r_credit <= r_credit - WW'(1);
                    end
                end else begin
                    // With every VC empty there is nowhere to go: stay put.
                    if (w_advance & ~w_none) begin
                        r_cur_vc <= w_next_vc;
                        r_credit <= w_next_vc_credit;
                    end else if (w_pop) begin
                        r_credit <= r_credit - WW'(1);
                    end
                end
            end
        end
    end

`ifdef QOS_SCHED_STATS_EN
    logic [QUEUE_QUANTITY*GCW-1:0] r_grant;

    // Per-VC saturating grant counters, cleared on a new start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= {(QUEUE_QUANTITY*GCW){1'b0}};
        end else if (enb) begin
            if (iniciar) begin
                r_grant <= {(QUEUE_QUANTITY*GCW){1'b0}};
            end else begin
                for (int v = 0; v < QUEUE_QUANTITY; v++) begin
                    if (vc_pop[v] && (r_grant[v*GCW +: GCW] != {GCW{1'b1}})) begin
                        r_grant[v*GCW +: GCW] <= r_grant[v*GCW +: GCW] + GCW'(1);
                    end
                end
            end
        end
    end

    assign grant_count = r_grant;
`endif

endmodule
